// File: rtl/regblock_adapter_sv_core.sv
// rtl/regblock_adapter_sv_core.sv - four-register CPU-interface register block with event counter and parity-protected scratch
module regblock_adapter_sv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_cpuif_req,
    input  logic        s_cpuif_req_is_wr,
    input  logic [3:0]  s_cpuif_addr,
    input  logic [31:0] s_cpuif_wr_data,
    input  logic [31:0] s_cpuif_wr_biten,
    output logic        s_cpuif_req_stall_wr,
    output logic        s_cpuif_req_stall_rd,
    output logic        s_cpuif_rd_ack,
    output logic        s_cpuif_rd_err,
    output logic [31:0] s_cpuif_rd_data,
    output logic        s_cpuif_wr_ack,
    output logic        s_cpuif_wr_err,
    input  logic [31:0] hwif_in_status,
    input  logic        hwif_in_evt_incr,
    input  logic        hwif_in_parity_flip,
    output logic [31:0] hwif_out_ctrl,
    output logic [15:0] hwif_out_evt_count,
    output logic [31:0] hwif_out_scratch,
    output logic        parity_error
);

    localparam logic [1:0]  WORD_CTRL     = 2'd0;
    localparam logic [1:0]  WORD_STATUS   = 2'd1;
    localparam logic [1:0]  WORD_EVT      = 2'd2;
    localparam logic [1:0]  WORD_SCRATCH  = 2'd3;
    localparam logic [31:0] SCRATCH_RESET = 32'hA5A5_A5A5;

    logic [31:0] ctrl_q;
    logic [15:0] evt_q;
    logic [31:0] scratch_q;
    logic        scratch_par_q;

    logic [1:0]  word;
    logic        wr_req;
    logic        rd_req;
    logic        wr_ctrl;
    logic        wr_evt;
    logic        wr_scratch;
    logic        wr_bad;
    logic [31:0] ctrl_wdata;
    logic [31:0] evt_wdata;
    logic [31:0] scratch_wdata;
    logic [31:0] rd_value;

    // Stalls are never needed: every request completes in a fixed single cycle.
    assign s_cpuif_req_stall_wr = 1'b0;
    assign s_cpuif_req_stall_rd = 1'b0;

    assign hwif_out_ctrl      = ctrl_q;
    assign hwif_out_evt_count = evt_q;
    assign hwif_out_scratch   = scratch_q;

    // Address decode, bit-masked write data and read mux from current register state.
    always_comb begin
        word          = s_cpuif_addr[3:2];
        wr_req        = s_cpuif_req & s_cpuif_req_is_wr;
        rd_req        = s_cpuif_req & ~s_cpuif_req_is_wr;
        wr_ctrl       = wr_req && (word == WORD_CTRL);
        wr_evt        = wr_req && (word == WORD_EVT);
        wr_scratch    = wr_req && (word == WORD_SCRATCH);
        wr_bad        = wr_req && (word == WORD_STATUS);
        ctrl_wdata    = (ctrl_q & ~s_cpuif_wr_biten) | (s_cpuif_wr_data & s_cpuif_wr_biten);
        evt_wdata     = ({16'h0000, evt_q} & ~s_cpuif_wr_biten) | (s_cpuif_wr_data & s_cpuif_wr_biten);
        scratch_wdata = (scratch_q & ~s_cpuif_wr_biten) | (s_cpuif_wr_data & s_cpuif_wr_biten);
        rd_value      = 32'h0000_0000;
        case (word)
            WORD_CTRL:    rd_value = ctrl_q;
            WORD_STATUS:  rd_value = hwif_in_status;
            WORD_EVT:     rd_value = {16'h0000, evt_q};
            WORD_SCRATCH: rd_value = scratch_q;
            default:      rd_value = 32'h0000_0000;
        endcase
    end

    // Response channel: acks one cycle after the request, read data zero unless acking a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_cpuif_rd_ack  <= 1'b0;
            s_cpuif_rd_err  <= 1'b0;
            s_cpuif_rd_data <= 32'h0000_0000;
            s_cpuif_wr_ack  <= 1'b0;
            s_cpuif_wr_err  <= 1'b0;
        end else begin
            s_cpuif_rd_ack  <= rd_req;
            s_cpuif_rd_err  <= 1'b0;
            s_cpuif_rd_data <= rd_req ? rd_value : 32'h0000_0000;
            s_cpuif_wr_ack  <= wr_req;
            s_cpuif_wr_err  <= wr_bad;
        end
    end

    // CTRL register: plain bit-masked read/write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= 32'h0000_0000;
        end else if (wr_ctrl) begin
            ctrl_q <= ctrl_wdata;
        end
    end

    // EVT counter: a CPU write wins over a same-cycle increment; increments saturate at 0xFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= 16'h0000;
        end else if (wr_evt) begin
            evt_q <= evt_wdata[15:0];
        end else if (hwif_in_evt_incr && (evt_q != 16'hFFFF)) begin
            evt_q <= evt_q + 16'd1;
        end
    end

    // SCRATCH with stored parity; fault injection flips bit 0 but leaves parity stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q     <= SCRATCH_RESET;
            scratch_par_q <= ^SCRATCH_RESET;
        end else if (wr_scratch) begin
            scratch_q     <= scratch_wdata;
            scratch_par_q <= ^scratch_wdata;
        end else if (hwif_in_parity_flip) begin
            scratch_q[0]  <= ~scratch_q[0];
        end
    end

    // Parity checker: flags one cycle after stored parity disagrees with the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_error <= 1'b0;
        end else begin
            parity_error <= (^scratch_q) != scratch_par_q;
        end
    end

endmodule

// File: tb/tb_regblock_adapter_sv_core.sv
// tb/tb_regblock_adapter_sv_core.sv - directed self-checking bench for regblock_adapter_sv_core
module tb_regblock_adapter_sv_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_cpuif_req;
    logic        s_cpuif_req_is_wr;
    logic [3:0]  s_cpuif_addr;
    logic [31:0] s_cpuif_wr_data;
    logic [31:0] s_cpuif_wr_biten;
    logic        s_cpuif_req_stall_wr;
    logic        s_cpuif_req_stall_rd;
    logic        s_cpuif_rd_ack;
    logic        s_cpuif_rd_err;
    logic [31:0] s_cpuif_rd_data;
    logic        s_cpuif_wr_ack;
    logic        s_cpuif_wr_err;
    logic [31:0] hwif_in_status;
    logic        hwif_in_evt_incr;
    logic        hwif_in_parity_flip;
    logic [31:0] hwif_out_ctrl;
    logic [15:0] hwif_out_evt_count;
    logic [31:0] hwif_out_scratch;
    logic        parity_error;

    int checks   = 0;
    int failures = 0;

    regblock_adapter_sv_core dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_cpuif_req          (s_cpuif_req),
        .s_cpuif_req_is_wr    (s_cpuif_req_is_wr),
        .s_cpuif_addr         (s_cpuif_addr),
        .s_cpuif_wr_data      (s_cpuif_wr_data),
        .s_cpuif_wr_biten     (s_cpuif_wr_biten),
        .s_cpuif_req_stall_wr (s_cpuif_req_stall_wr),
        .s_cpuif_req_stall_rd (s_cpuif_req_stall_rd),
        .s_cpuif_rd_ack       (s_cpuif_rd_ack),
        .s_cpuif_rd_err       (s_cpuif_rd_err),
        .s_cpuif_rd_data      (s_cpuif_rd_data),
        .s_cpuif_wr_ack       (s_cpuif_wr_ack),
        .s_cpuif_wr_err       (s_cpuif_wr_err),
        .hwif_in_status       (hwif_in_status),
        .hwif_in_evt_incr     (hwif_in_evt_incr),
        .hwif_in_parity_flip  (hwif_in_parity_flip),
        .hwif_out_ctrl        (hwif_out_ctrl),
        .hwif_out_evt_count   (hwif_out_evt_count),
        .hwif_out_scratch     (hwif_out_scratch),
        .parity_error         (parity_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request held for exactly one cycle; on return the response of that request is visible.
    task automatic cpu_req(input logic is_wr, input logic [3:0] addr, input logic [31:0] data, input logic [31:0] biten);
        s_cpuif_req       = 1'b1;
        s_cpuif_req_is_wr = is_wr;
        s_cpuif_addr      = addr;
        s_cpuif_wr_data   = data;
        s_cpuif_wr_biten  = biten;
        tick();
        s_cpuif_req       = 1'b0;
        s_cpuif_req_is_wr = 1'b0;
        s_cpuif_wr_data   = 32'h0;
        s_cpuif_wr_biten  = 32'h0;
    endtask

    initial begin
        rst                 = 1'b1;
        s_cpuif_req         = 1'b1;
        s_cpuif_req_is_wr   = 1'b1;
        s_cpuif_addr        = 4'h0;
        s_cpuif_wr_data     = 32'hFFFF_FFFF;
        s_cpuif_wr_biten    = 32'hFFFF_FFFF;
        hwif_in_status      = 32'h0;
        hwif_in_evt_incr    = 1'b1;
        hwif_in_parity_flip = 1'b1;

        // Requests and side inputs during reset are discarded.
        tick();
        tick();
        check("rst_wr_ack", {31'b0, s_cpuif_wr_ack}, 32'd0);
        check("rst_rd_ack", {31'b0, s_cpuif_rd_ack}, 32'd0);
        check("rst_rd_data", s_cpuif_rd_data, 32'h0);
        check("rst_ctrl", hwif_out_ctrl, 32'h0);
        check("rst_evt", {16'h0, hwif_out_evt_count}, 32'h0);
        check("rst_scratch", hwif_out_scratch, 32'hA5A5_A5A5);
        check("rst_parity_error", {31'b0, parity_error}, 32'd0);
        check("stall_wr", {31'b0, s_cpuif_req_stall_wr}, 32'd0);
        check("stall_rd", {31'b0, s_cpuif_req_stall_rd}, 32'd0);

        s_cpuif_req         = 1'b0;
        s_cpuif_req_is_wr   = 1'b0;
        hwif_in_evt_incr    = 1'b0;
        hwif_in_parity_flip = 1'b0;
        rst                 = 1'b0;
        tick();
        check("post_rst_parity_error", {31'b0, parity_error}, 32'd0);

        // Back-to-back reads after reset.
        cpu_req(1'b0, 4'h0, 32'h0, 32'h0);
        check("rd_ctrl_ack", {31'b0, s_cpuif_rd_ack}, 32'd1);
        check("rd_ctrl_data", s_cpuif_rd_data, 32'h0);
        check("rd_ctrl_err", {31'b0, s_cpuif_rd_err}, 32'd0);
        cpu_req(1'b0, 4'h8, 32'h0, 32'h0);
        check("rd_evt_ack", {31'b0, s_cpuif_rd_ack}, 32'd1);
        check("rd_evt_data", s_cpuif_rd_data, 32'h0);
        cpu_req(1'b0, 4'hC, 32'h0, 32'h0);
        check("rd_scratch_ack", {31'b0, s_cpuif_rd_ack}, 32'd1);
        check("rd_scratch_data", s_cpuif_rd_data, 32'hA5A5_A5A5);
        check("rd_scratch_err", {31'b0, s_cpuif_rd_err}, 32'd0);
        check("rd_wr_ack_quiet", {31'b0, s_cpuif_wr_ack}, 32'd0);
        tick();
        check("idle_rd_ack", {31'b0, s_cpuif_rd_ack}, 32'd0);
        check("idle_rd_data", s_cpuif_rd_data, 32'h0);

        // Partial write to CTRL, then readback; low address bits ignored.
        cpu_req(1'b1, 4'h0, 32'h1234_5678, 32'h0000_FFFF);
        check("wr_ctrl_ack", {31'b0, s_cpuif_wr_ack}, 32'd1);
        check("wr_ctrl_err", {31'b0, s_cpuif_wr_err}, 32'd0);
        check("wr_ctrl_rd_data_zero", s_cpuif_rd_data, 32'h0);
        check("ctrl_out", hwif_out_ctrl, 32'h0000_5678);
        cpu_req(1'b0, 4'h3, 32'h0, 32'h0);
        check("ctrl_readback", s_cpuif_rd_data, 32'h0000_5678);

        // Event counter: increment, saturation, write priority.
        hwif_in_evt_incr = 1'b1;
        tick();
        tick();
        tick();
        hwif_in_evt_incr = 1'b0;
        check("evt_incr3", {16'h0, hwif_out_evt_count}, 32'd3);
        cpu_req(1'b1, 4'h8, 32'h0000_FFFE, 32'hFFFF_FFFF);
        check("evt_preload", {16'h0, hwif_out_evt_count}, 32'h0000_FFFE);
        hwif_in_evt_incr = 1'b1;
        tick();
        tick();
        tick();
        hwif_in_evt_incr = 1'b0;
        check("evt_saturate", {16'h0, hwif_out_evt_count}, 32'h0000_FFFF);
        cpu_req(1'b0, 4'h8, 32'h0, 32'h0);
        check("evt_readback_upper0", s_cpuif_rd_data, 32'h0000_FFFF);
        hwif_in_evt_incr = 1'b1;
        cpu_req(1'b1, 4'h8, 32'h0, 32'hFFFF_FFFF);
        hwif_in_evt_incr = 1'b0;
        check("evt_write_priority", {16'h0, hwif_out_evt_count}, 32'h0);

        // STATUS: read returns the input, write is rejected without side effects.
        hwif_in_status = 32'hDEAD_BEEF;
        cpu_req(1'b0, 4'h4, 32'h0, 32'h0);
        check("status_read", s_cpuif_rd_data, 32'hDEAD_BEEF);
        cpu_req(1'b1, 4'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("status_wr_ack", {31'b0, s_cpuif_wr_ack}, 32'd1);
        check("status_wr_err", {31'b0, s_cpuif_wr_err}, 32'd1);
        check("status_wr_ctrl_kept", hwif_out_ctrl, 32'h0000_5678);
        check("status_wr_evt_kept", {16'h0, hwif_out_evt_count}, 32'h0);
        check("status_wr_scratch_kept", hwif_out_scratch, 32'hA5A5_A5A5);

        // Parity fault injection and recovery.
        hwif_in_parity_flip = 1'b1;
        tick();
        hwif_in_parity_flip = 1'b0;
        check("flip_scratch", hwif_out_scratch, 32'hA5A5_A5A4);
        check("flip_perr_not_yet", {31'b0, parity_error}, 32'd0);
        tick();
        check("flip_perr_set", {31'b0, parity_error}, 32'd1);
        cpu_req(1'b1, 4'hC, 32'h0000_0001, 32'hFFFF_FFFF);
        check("scratch_wr", hwif_out_scratch, 32'h0000_0001);
        tick();
        check("perr_cleared", {31'b0, parity_error}, 32'd0);

        // Same-cycle SCRATCH write beats the flip.
        hwif_in_parity_flip = 1'b1;
        cpu_req(1'b1, 4'hC, 32'h0000_FF00, 32'hFFFF_FFFF);
        hwif_in_parity_flip = 1'b0;
        check("flip_vs_write", hwif_out_scratch, 32'h0000_FF00);
        tick();
        check("flip_vs_write_perr", {31'b0, parity_error}, 32'd0);

        // Reset asserted while a request is presented: no ack, state restored.
        s_cpuif_req       = 1'b1;
        s_cpuif_req_is_wr = 1'b0;
        s_cpuif_addr      = 4'hC;
        rst               = 1'b1;
        tick();
        s_cpuif_req = 1'b0;
        rst         = 1'b0;
        check("midrst_rd_ack", {31'b0, s_cpuif_rd_ack}, 32'd0);
        check("midrst_rd_data", s_cpuif_rd_data, 32'h0);
        check("midrst_ctrl", hwif_out_ctrl, 32'h0);
        check("midrst_scratch", hwif_out_scratch, 32'hA5A5_A5A5);
        tick();
        check("midrst_no_late_ack", {31'b0, s_cpuif_rd_ack}, 32'd0);
        check("midrst_perr", {31'b0, parity_error}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/regblock_adapter_sv_core.md
REGBLOCK_ADAPTER_SV_CORE -- requirements
Module: regblock_adapter_sv

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 SHALL have s_cpuif_req  input  1  request strobe, valid for one cycle.
REQ-003 SHALL have s_cpuif_req_is_wr  input  1  1 = write, 0 = read.
REQ-004 SHALL have s_cpuif_addr  input  4  byte address, word aligned; bits [1:0] ignored.
REQ-005 SHALL have s_cpuif_wr_data / s_cpuif_wr_biten  input  32 each  write data and per-bit write enable.
REQ-006 SHALL have s_cpuif_req_stall_wr / s_cpuif_req_stall_rd  output  1 each  tied to 0.
REQ-007 SHALL have s_cpuif_rd_ack, s_cpuif_rd_err, s_cpuif_wr_ack, s_cpuif_wr_err  output  1 each; s_cpuif_rd_data  output  32.
REQ-008 SHALL have hwif_in_status  input  32  status value; hwif_in_evt_incr  input  1  event increment; hwif_in_parity_flip  input  1  fault injection.
REQ-009 SHALL have hwif_out_ctrl  output  32; hwif_out_evt_count  output  16; hwif_out_scratch  output  32; parity_error  output  1.

Function
REQ-010 Register map SHALL be: 0x0 CTRL (rw, 32b), 0x4 STATUS (ro, 32b), 0x8 EVT (rw counter, 16b in bits [15:0]), 0xC SCRATCH (rw, 32b, parity-protected).
REQ-011 Every request SHALL be acknowledged exactly one cycle after req, via rd_ack or wr_ack, both registered; back-to-back requests on consecutive cycles SHALL all be acked.
REQ-012 Writes SHALL update only bits whose wr_biten bit is 1, and take effect on the clock edge at which req is sampled.
REQ-013 Reads SHALL return the register value at the edge where req is sampled; STATUS returns hwif_in_status sampled at that edge; EVT bits [31:16] read 0.
REQ-014 s_cpuif_rd_data SHALL be 0 in every cycle where rd_ack is 0.
REQ-015 Write to STATUS or any unmapped address SHALL have no effect, with wr_ack=1 and wr_err=1.
REQ-016 Reads of mapped addresses SHALL give rd_err=0; all four addresses are mapped.
REQ-017 EVT SHALL increment by 1 per cycle with hwif_in_evt_incr=1, saturating at 0xFFFF with no wrap.
REQ-018 An EVT write SHALL take priority over a same-cycle increment.
REQ-019 SCRATCH SHALL store a parity bit equal to the XOR of its 32 data bits, recomputed on every SCRATCH write.
REQ-020 hwif_in_parity_flip=1 SHALL invert SCRATCH bit 0 without updating the stored parity; a same-cycle SCRATCH write takes priority.
REQ-021 parity_error SHALL be registered, equal to 1 in the cycle after XOR(data) != stored parity, and clear once parity is consistent again.
REQ-022 hwif_out_ctrl, hwif_out_evt_count and hwif_out_scratch SHALL continuously reflect the current register contents, and SHALL never be X/Z after reset.

Reset
REQ-023 While rst=1 the block SHALL set: CTRL=0x0000_0000, EVT=0x0000, SCRATCH=0xA5A5_A5A5 with consistent parity, all acks and errs 0, rd_data 0, and parity_error 0.
REQ-024 A request sampled while rst=1 SHALL be discarded with no ack, including during reset asserted mid-transaction.

Verification
REQ-025 After reset, read 0x0, 0x8, 0xC -> rd_data 0x0, 0x0, 0xA5A5A5A5, one cycle later each, with rd_err=0.
REQ-026 Write 0x0 with data 0x12345678, biten 0x0000FFFF -> hwif_out_ctrl=0x00005678 on the next cycle, and a readback gives the same value.
REQ-027 Pulse hwif_in_evt_incr for 3 cycles -> EVT=3; preload 0xFFFE then increment 3 times -> 0xFFFF; write 0 with incr=1 -> 0.
REQ-028 Set hwif_in_status=0xDEADBEEF and read 0x4 -> 0xDEADBEEF; write 0x4 -> wr_err=1 and no register changes.
REQ-029 Pulse hwif_in_parity_flip once -> SCRATCH=0xA5A5A5A4 and parity_error=1; then write 0xC with 0x1, biten all ones -> parity_error=0 on the following cycle.
